// File: rtl/control_sequencer.sv
// Instruction sequencer for a small load/store datapath. It fetches a 16-bit
// instruction, decodes it in a single EXEC cycle, and optionally waits in MEM
// for a load/store handshake. It drives the datapath selects and owns the
// program counter. HALT is sticky and is cleared only by reset.
//
// state | meaning
// FETCH | drive PC onto memory (MM=1), latch IR when mem_ready
// EXEC  | one-cycle decode of IR[15:12], update PC or branch off to MEM/HALT
// MEM   | LD/ST access, held until mem_ready, then PC+1
// HALT  | frozen, all strobes low, halted=1
module control_sequencer #(
  parameter logic [3:0] FS_ADD   = 4'h2,
  parameter logic [3:0] FS_PASSA = 4'h0,
  parameter logic [3:0] FS_PASSB = 4'hA,
  parameter logic [5:0] PC_RESET = 6'd0
) (
  input  logic        clk_main,
  input  logic        reset,
  input  logic [15:0] IR_in,
  input  logic        mem_ready,
  input  logic        Z,
  input  logic [5:0]  AddrIn,
  output logic [5:0]  PC,
  output logic [3:0]  DR,
  output logic [3:0]  SA,
  output logic [3:0]  SB,
  output logic [3:0]  FS,
  output logic        MB,
  output logic        MM,
  output logic        MD,
  output logic        RW,
  output logic        MW,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_pc;
  logic [5:0]  w_pc_next;
  logic [15:0] r_ir;
  logic [15:0] w_ir_next;
  logic [3:0]  w_op;
  logic [5:0]  w_pc_inc;
  logic [5:0]  w_pc_branch;

  assign w_op        = r_ir[15:12];
  // 6-bit adds wrap naturally, giving modulo-64 PC arithmetic in both directions
  assign w_pc_inc    = r_pc + 6'd1;
  assign w_pc_branch = r_pc + {{2{r_ir[11]}}, r_ir[11:8]};

  assign PC = r_pc;
  assign DR = r_ir[11:8];
  assign SA = r_ir[7:4];
  assign SB = r_ir[3:0];

  // State, PC and IR registers; IR resets to a NOP encoding
  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_ir    <= 16'hF000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Next-state, next-PC and datapath control decode
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    FS           = 4'h0;
    MB           = 1'b0;
    MM           = 1'b0;
    MD           = 1'b0;
    RW           = 1'b0;
    MW           = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_FETCH: begin
        MM = 1'b1;
        if (mem_ready) begin
          w_ir_next    = IR_in;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_FETCH;
        case (w_op)
          4'h8: begin
            FS        = FS_ADD;
            MB        = 1'b1;
            RW        = 1'b1;
            w_pc_next = w_pc_inc;
          end
          4'h9, 4'hA: w_state_next = S_MEM;
          4'hB: begin
            FS        = FS_PASSA;
            w_pc_next = Z ? w_pc_branch : w_pc_inc;
          end
          4'hC: w_pc_next = r_ir[5:0];
          4'hD: w_pc_next = AddrIn;
          4'hE: w_state_next = S_HALT;
          4'hF: w_pc_next = w_pc_inc;
          // opcodes 0x0-0x7 are register-register ALU operations
          default: begin
            FS        = {1'b0, w_op[2:0]};
            RW        = 1'b1;
            w_pc_next = w_pc_inc;
          end
        endcase
      end
      S_MEM: begin
        if (w_op == 4'h9) begin
          MD = 1'b1;
          RW = mem_ready;
        end else begin
          FS = FS_PASSB;
          MW = 1'b1;
        end
        if (mem_ready) begin
          w_pc_next    = w_pc_inc;
          w_state_next = S_FETCH;
        end
      end
      S_HALT: halted = 1'b1;
      default: w_state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: reset state, a table of single-instruction
// EXEC vectors, hand-written LD/ST/HALT sequences, and a random instruction
// stream compared cycle by cycle against a behavioural model.
module tb_control_sequencer;

  logic        clk_main = 1'b0;
  logic        reset;
  logic [15:0] IR_in;
  logic        mem_ready;
  logic        Z;
  logic [5:0]  AddrIn;
  logic [5:0]  PC;
  logic [3:0]  DR, SA, SB, FS;
  logic        MB, MM, MD, RW, MW, halted;

  int n_pass  = 0;
  int n_total = 0;

  control_sequencer dut (
    .clk_main (clk_main),
    .reset    (reset),
    .IR_in    (IR_in),
    .mem_ready(mem_ready),
    .Z        (Z),
    .AddrIn   (AddrIn),
    .PC       (PC),
    .DR       (DR),
    .SA       (SA),
    .SB       (SB),
    .FS       (FS),
    .MB       (MB),
    .MM       (MM),
    .MD       (MD),
    .RW       (RW),
    .MW       (MW),
    .halted   (halted)
  );

  always #5 clk_main = ~clk_main;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  // pulse reset just after an edge; next edge performs the first fetch
  task automatic do_reset();
    @(posedge clk_main);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic fetch(input logic [15:0] ir);
    IR_in     = ir;
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic set_pc(input logic [5:0] p);
    fetch(16'hC000 | {10'd0, p});
    mem_ready = 1'b0;
    tick();
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 fetch, 1 exec, 2 mem, 3 halt
  int          m_phase;
  logic [5:0]  m_pc;
  logic [15:0] m_ir;
  int          halt_cnt;

  function automatic logic [5:0] wrap(input int v);
    return 6'(((v % 64) + 64) % 64);
  endfunction

  // expected {PC, DR, SA, SB, FS, MB, MM, MD, RW, MW, halted}
  function automatic logic [27:0] model_out(input logic mr);
    int         op;
    logic [3:0] fs;
    logic       mb, mm, md, rw, mw, hl;
    op = int'(m_ir[15:12]);
    fs = 4'h0; mb = 0; mm = 0; md = 0; rw = 0; mw = 0; hl = 0;
    if (m_phase == 0) mm = 1;
    else if (m_phase == 1) begin
      if (op < 8) begin fs = 4'(op); rw = 1; end
      else if (op == 8) begin fs = 4'h2; mb = 1; rw = 1; end
    end else if (m_phase == 2) begin
      if (op == 9) begin md = 1; rw = mr; end
      else begin fs = 4'hA; mw = 1; end
    end else hl = 1;
    return {m_pc, m_ir[11:0], fs, mb, mm, md, rw, mw, hl};
  endfunction

  task automatic model_step(input logic mr, input logic z, input logic [5:0] addr,
                            input logic [15:0] ir_bus);
    int op, off;
    op  = int'(m_ir[15:12]);
    off = m_ir[11] ? int'(m_ir[11:8]) - 16 : int'(m_ir[11:8]);
    case (m_phase)
      0: if (mr) begin m_ir = ir_bus; m_phase = 1; end
      1: begin
        m_phase = 0;
        if (op <= 8 || op == 15) m_pc = wrap(int'(m_pc) + 1);
        else if (op == 9 || op == 10) m_phase = 2;
        else if (op == 11) m_pc = wrap(int'(m_pc) + (z ? off : 1));
        else if (op == 12) m_pc = m_ir[5:0];
        else if (op == 13) m_pc = addr;
        else m_phase = 3;
      end
      2: if (mr) begin m_pc = wrap(int'(m_pc) + 1); m_phase = 0; end
      default: halt_cnt++;
    endcase
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_pc     = 6'd0;
    m_ir     = 16'hF000;
    halt_cnt = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  pc0;
    logic [15:0] ir;
    logic        z;
    logic [5:0]  addr;
    logic [3:0]  fs;
    logic        mb;
    logic        rw;
    logic [5:0]  pc1;
  } vec_t;

  vec_t vecs[11];

  logic [27:0] w_act;
  assign w_act = {PC, DR, SA, SB, FS, MB, MM, MD, RW, MW, halted};

  initial begin
    vecs[0]  = '{6'd0,  16'h8123, 1'b0, 6'd0,  4'h2, 1'b1, 1'b1, 6'd1};
    vecs[1]  = '{6'd5,  16'hBE00, 1'b1, 6'd0,  4'h0, 1'b0, 1'b0, 6'd3};
    vecs[2]  = '{6'd5,  16'hBE00, 1'b0, 6'd0,  4'h0, 1'b0, 1'b0, 6'd6};
    vecs[3]  = '{6'd63, 16'hF000, 1'b0, 6'd0,  4'h0, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{6'd7,  16'hD000, 1'b0, 6'd42, 4'h0, 1'b0, 1'b0, 6'd42};
    vecs[5]  = '{6'd3,  16'h3456, 1'b1, 6'd9,  4'h3, 1'b0, 1'b1, 6'd4};
    vecs[6]  = '{6'd10, 16'hC025, 1'b0, 6'd0,  4'h0, 1'b0, 1'b0, 6'd37};
    vecs[7]  = '{6'd63, 16'h8123, 1'b0, 6'd0,  4'h2, 1'b1, 1'b1, 6'd0};
    vecs[8]  = '{6'd1,  16'hB800, 1'b1, 6'd0,  4'h0, 1'b0, 1'b0, 6'd57};
    vecs[9]  = '{6'd62, 16'hB700, 1'b1, 6'd0,  4'h0, 1'b0, 1'b0, 6'd5};
    vecs[10] = '{6'd20, 16'h7000, 1'b0, 6'd0,  4'h7, 1'b0, 1'b1, 6'd21};

    reset     = 1'b0;
    IR_in     = 16'h0000;
    mem_ready = 1'b0;
    Z         = 1'b0;
    AddrIn    = 6'd0;

    // reset state
    #2;
    check("reset_state", w_act, {6'd0, 12'h000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    #1;
    reset = 1'b1;

    // EXEC table
    for (int i = 0; i < 11; i++) begin
      do_reset();
      set_pc(vecs[i].pc0);
      fetch(vecs[i].ir);
      Z         = vecs[i].z;
      AddrIn    = vecs[i].addr;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("vec%0d_exec", i), {FS, MB, RW, MW, MD, MM, halted, DR, PC},
            {vecs[i].fs, vecs[i].mb, vecs[i].rw, 4'b0000, vecs[i].ir[11:8], vecs[i].pc0});
      tick();
      mem_ready = 1'b0;
      #1;
      check($sformatf("vec%0d_pc", i), {PC, MM}, {vecs[i].pc1, 1'b1});
      Z      = 1'b0;
      AddrIn = 6'd0;
    end

    // LD with three wait states
    do_reset();
    set_pc(6'd10);
    fetch(16'h9123);
    mem_ready = 1'b1;
    #1;
    check("ld_exec", {PC, RW, MD}, {6'd10, 1'b0, 1'b0});
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      check($sformatf("ld_wait%0d", i), {MD, RW, MM, MW, PC}, {4'b1000, 6'd10});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("ld_done", {MD, RW, MM, MW}, 4'b1100);
    tick();
    mem_ready = 1'b0;
    #1;
    check("ld_after", {PC, MD, RW, MM}, {6'd11, 3'b001});

    // ST held in wait, then reset mid-MEM
    do_reset();
    set_pc(6'd9);
    fetch(16'hA0F5);
    mem_ready = 1'b1;
    #1;
    check("st_exec", MW, 1'b0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("st_wait0", {MW, FS, MM}, {1'b1, 4'hA, 1'b0});
    tick();
    check("st_wait1", {MW, FS, PC}, {1'b1, 4'hA, 6'd9});
    reset = 1'b0;
    #1;
    check("st_reset", {MW, RW, MM, halted, PC}, {4'b0010, 6'd0});
    reset = 1'b1;
    fetch(16'hF000);
    mem_ready = 1'b0;
    tick();
    check("st_refetch", {PC, MM}, {6'd1, 1'b1});

    // HALT is sticky regardless of mem_ready
    do_reset();
    set_pc(6'd12);
    fetch(16'hE000);
    tick();
    for (int i = 0; i < 25; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      IR_in     = 16'($urandom);
      #1;
      check($sformatf("halt%0d", i), {halted, PC, RW, MW, MM}, {1'b1, 6'd12, 3'b000});
      tick();
    end
    reset = 1'b0;
    #1;
    check("halt_reset", {halted, PC, MM}, {1'b0, 6'd0, 1'b1});
    reset = 1'b1;

    // random instruction stream against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] op;
      if ((m_phase == 3 && halt_cnt >= 4) || $urandom_range(0, 79) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check("rand_reset", w_act, model_out(mem_ready));
        reset = 1'b1;
      end
      op = 4'($urandom_range(0, 15));
      if (op == 4'hE && $urandom_range(0, 3) != 0) op = 4'hF;
      IR_in     = {op, 12'($urandom)};
      mem_ready = 1'($urandom_range(0, 1));
      Z         = 1'($urandom_range(0, 1));
      AddrIn    = 6'($urandom);
      #1;
      check($sformatf("rand%0d", c), w_act, model_out(mem_ready));
      model_step(mem_ready, Z, AddrIn, IR_in);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
